// File: rtl/byte_packer.sv
// byte_packer
//   Packs a ready/valid byte stream into words of BYTES bytes. The first byte
//   of a word lands in bits [IN_W-1:0]. A byte flagged with io_in_last closes
//   the word early. The unfilled upper bytes of such a word are zero.
//   The finished word sits in an output register until the consumer takes it.
//   A word that completes in the same cycle as the held word is taken replaces
//   the held word directly, so a continuous stream runs at one byte per cycle.
//
// Ports
//   clk           sole clock; all state changes on its rising edge
//   reset         asynchronous, active-low reset
//   io_in_ready   a byte can be accepted (= !io_out_valid | io_out_ready)
//   io_in_valid   a byte is offered
//   io_in_bits    byte data
//   io_in_last    the offered byte closes the current word
//   io_out_ready  the consumer accepts the held word
//   io_out_valid  the output register holds a word
//   io_out_bits   packed word
//   io_out_count  number of valid bytes in the word (1..BYTES)
//   io_out_last   the word was closed by io_in_last
//
// Optional build macro
//   BYTE_PACKER_TIMEOUT_EN  When defined, a partial word is flushed after
//                           TIMEOUT idle cycles. The flushed word has
//                           last=0 and count=idx.

module byte_packer #(
    parameter int IN_W    = 8,
    parameter int BYTES   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   io_in_ready,
    input  logic                   io_in_valid,
    input  logic [IN_W-1:0]        io_in_bits,
    input  logic                   io_in_last,
    input  logic                   io_out_ready,
    output logic                   io_out_valid,
    output logic [IN_W*BYTES-1:0]  io_out_bits,
    output logic [$clog2(BYTES):0] io_out_count,
    output logic                   io_out_last
);

    localparam int OUT_W = IN_W * BYTES;
    localparam int CNT_W = $clog2(BYTES) + 1;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [IDX_W-1:0] idx;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] merged;
    logic             in_fire;
    logic             out_fire;
    logic             complete;
    logic             flush;

    // A slot frees up when the held word leaves in this same cycle.
    // The ready signal looks only at the output side.
    assign io_in_ready = !io_out_valid || io_out_ready;
    assign in_fire     = io_in_valid && io_in_ready;
    assign out_fire    = io_out_valid && io_out_ready;
    assign complete    = in_fire && ((idx == IDX_W'(BYTES - 1)) || io_in_last);

    // Accumulator with the incoming byte placed in its slot. This value feeds
    // both the accumulator update and the output load, so a completing byte
    // reaches the output without an extra cycle.
    always_comb begin
        merged = acc;
        merged[idx*IN_W +: IN_W] = io_in_bits;
    end

`ifdef BYTE_PACKER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_cnt;

    // Counts idle cycles while a partial word is pending. The count saturates.
    // Any accepted byte, or an empty accumulator, restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (in_fire || (idx == '0) || flush) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_W'(TIMEOUT)) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    // A flush needs room in the output register. It never fires in a cycle
    // where a byte is accepted; the accepted byte takes priority.
    // With io_in_ready high, that means no byte is being offered.
    assign flush = (idle_cnt == IDLE_W'(TIMEOUT)) && (idx != '0) &&
                   io_in_ready && !io_in_valid;
`else
    logic unused_timeout;

    // TIMEOUT only has an effect when the idle flush is compiled in.
    assign unused_timeout = (TIMEOUT == 0);
    assign flush          = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx          <= '0;
            acc          <= '0;
            io_out_valid <= 1'b0;
            io_out_bits  <= '0;
            io_out_count <= '0;
            io_out_last  <= 1'b0;
        end else if (complete) begin
            // This branch also covers reloading while the old word leaves.
            io_out_bits  <= merged;
            io_out_count <= CNT_W'(idx) + CNT_W'(1);
            io_out_last  <= io_in_last;
            io_out_valid <= 1'b1;
            idx          <= '0;
            acc          <= '0;
        end else if (flush) begin
            io_out_bits  <= acc;
            io_out_count <= CNT_W'(idx);
            io_out_last  <= 1'b0;
            io_out_valid <= 1'b1;
            idx          <= '0;
            acc          <= '0;
        end else begin
            if (in_fire) begin
                acc <= merged;
                idx <= idx + IDX_W'(1);
            end
            // A taken word keeps bits/count/last; only valid drops.
            if (out_fire) begin
                io_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_byte_packer.sv
// tb_byte_packer
//   Directed bench for byte_packer (IN_W=8, BYTES=4, TIMEOUT=16).
//   Bytes are driven from one initial block. Each word the stimulus should
//   produce is pushed to a queue. A negedge monitor pops the queue and
//   compares against every word the DUT hands over.

module tb_byte_packer;

    localparam int IN_W  = 8;
    localparam int BYTES = 4;
    localparam int OUT_W = 32;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             io_in_ready;
    logic             io_in_valid = 1'b0;
    logic [IN_W-1:0]  io_in_bits = '0;
    logic             io_in_last = 1'b0;
    logic             io_out_ready = 1'b0;
    logic             io_out_valid;
    logic [OUT_W-1:0] io_out_bits;
    logic [CNT_W-1:0] io_out_count;
    logic             io_out_last;

    typedef struct {
        logic [OUT_W-1:0] bits;
        logic [CNT_W-1:0] count;
        logic             last;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int words_seen = 0;

    logic [OUT_W-1:0] model_acc = '0;
    int               model_idx = 0;

    byte_packer #(.IN_W(IN_W), .BYTES(BYTES), .TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_in_ready  (io_in_ready),
        .io_in_valid  (io_in_valid),
        .io_in_bits   (io_in_bits),
        .io_in_last   (io_in_last),
        .io_out_ready (io_out_ready),
        .io_out_valid (io_out_valid),
        .io_out_bits  (io_out_bits),
        .io_out_count (io_out_count),
        .io_out_last  (io_out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference packing: build the word byte by byte.
    // Push the word once it is full or closed by last.
    task automatic model_accept(input logic [7:0] b, input logic l);
        exp_t e;
        model_acc[model_idx*8 +: 8] = b;
        if (model_idx == BYTES - 1 || l) begin
            e.bits  = model_acc;
            e.count = CNT_W'(model_idx + 1);
            e.last  = l;
            sb.push_back(e);
            model_acc = '0;
            model_idx = 0;
        end else begin
            model_idx++;
        end
    endtask

    task automatic model_reset();
        sb.delete();
        model_acc = '0;
        model_idx = 0;
    endtask

    // Offers one byte and returns 1 time unit after the edge that accepts it.
    // The byte stays offered, so back-to-back calls stream without gaps.
    task automatic send(input logic [7:0] b, input logic l);
        int n = 0;
        io_in_valid = 1'b1;
        io_in_bits  = b;
        io_in_last  = l;
        @(negedge clk);
        while (!io_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!io_in_ready) begin
            check("in_ready_wait", 64'(io_in_ready), 64'd1);
            io_in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            model_accept(b, l);
        end
    endtask

    task automatic idle();
        io_in_valid = 1'b0;
        io_in_last  = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset && io_out_valid && io_out_ready) begin
            words_seen++;
            check("word_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("word_bits", 64'(io_out_bits), 64'(e.bits));
                check("word_count", 64'(io_out_count), 64'(e.count));
                check("word_last", 64'(io_out_last), 64'(e.last));
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(io_out_valid), 64'd0);
        check("rst_bits", 64'(io_out_bits), 64'd0);
        check("rst_count", 64'(io_out_count), 64'd0);
        check("rst_last", 64'(io_out_last), 64'd0);
        check("rst_in_ready", 64'(io_in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Full word
        io_out_ready = 1'b1;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        idle();
        check("full_valid", 64'(io_out_valid), 64'd1);
        check("full_bits", 64'(io_out_bits), 64'h44332211);
        @(posedge clk);
        #1;

        // Early last
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        idle();
        check("early_bits", 64'(io_out_bits), 64'h0000BBAA);
        check("early_count", 64'(io_out_count), 64'd2);
        check("early_last", 64'(io_out_last), 64'd1);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure
        io_out_ready = 1'b0;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        io_in_valid = 1'b1;
        io_in_bits  = 8'h05;
        io_in_last  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(io_in_ready), 64'd0);
            check("bp_hold_bits", 64'(io_out_bits), 64'h04030201);
            check("bp_hold_count", 64'(io_out_count), 64'd4);
        end
        @(posedge clk);
        #1;
        io_out_ready = 1'b1;
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        send(8'h07, 1'b0);
        send(8'h08, 1'b0);
        idle();
        check("bp_second_bits", 64'(io_out_bits), 64'h08070605);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back streaming at one byte per cycle
        for (int k = 1; k <= 8; k++) begin
            send(8'(k), 1'b0);
            check("b2b_in_ready", 64'(io_in_ready), 64'd1);
            if (k == 4 || k == 8) begin
                check("b2b_valid_word", 64'(io_out_valid), 64'd1);
            end
            if (k == 5) begin
                check("b2b_valid_gap", 64'(io_out_valid), 64'd0);
            end
        end
        // Single-byte words: the output register reloads every cycle
        send(8'hE1, 1'b1);
        check("reload1_bits", 64'(io_out_bits), 64'h000000E1);
        send(8'hE2, 1'b1);
        check("reload2_valid", 64'(io_out_valid), 64'd1);
        check("reload2_bits", 64'(io_out_bits), 64'h000000E2);
        send(8'hE3, 1'b1);
        check("reload3_valid", 64'(io_out_valid), 64'd1);
        check("reload3_bits", 64'(io_out_bits), 64'h000000E3);
        check("reload3_count", 64'(io_out_count), 64'd1);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset discards a held word immediately
        io_out_ready = 1'b0;
        send(8'hD1, 1'b1);
        idle();
        check("held_valid", 64'(io_out_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("async_valid", 64'(io_out_valid), 64'd0);
        check("async_bits", 64'(io_out_bits), 64'd0);
        check("async_count", 64'(io_out_count), 64'd0);
        check("async_in_ready", 64'(io_in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-word
        io_out_ready = 1'b1;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        idle();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("mid_rst_valid", 64'(io_out_valid), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        idle();
        check("mid_rst_bits", 64'(io_out_bits), 64'h66554433);
        check("mid_rst_count", 64'(io_out_count), 64'd4);
        repeat (2) @(posedge clk);
        #1;

        // Partial word left idle
        send(8'h5A, 1'b0);
        idle();
`ifdef BYTE_PACKER_TIMEOUT_EN
        model_reset();
        begin
            exp_t e;
            e.bits  = 32'h0000005A;
            e.count = 3'd1;
            e.last  = 1'b0;
            sb.push_back(e);
        end
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            check("to_wait_valid", 64'(io_out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        check("to_flush_valid", 64'(io_out_valid), 64'd1);
        check("to_flush_bits", 64'(io_out_bits), 64'h0000005A);
        check("to_flush_count", 64'(io_out_count), 64'd1);
        check("to_flush_last", 64'(io_out_last), 64'd0);
`else
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            check("no_to_valid", 64'(io_out_valid), 64'd0);
        end
        send(8'hA5, 1'b1);
        idle();
        check("no_to_bits", 64'(io_out_bits), 64'h0000A55A);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("words_min", 64'(words_seen >= 8), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
